// File: rtl/booth_mul_seq_pkg.sv
// Shared definitions for the sequential Booth multiplier.
//   - operand width and iteration bounds
//   - controller state encoding
//   - Booth pair codes and the helper that turns a pair into an adder operand
package booth_mul_seq_pkg;

    localparam int WIDTH     = 32;
    localparam int CNT_W     = 5;
    localparam int LAST_ITER = 31;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // {Q[0], q_1} codes that need the adder to do real work.
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    typedef struct packed {
        logic [WIDTH-1:0] b;
        logic             carry_in;
    } addend_t;

    // Subtraction is done as A + ~M + 1. The 00/11 case still drives a
    // defined zero so the adder never sees X.
    function automatic addend_t booth_addend(input logic [1:0]       pair,
                                             input logic [WIDTH-1:0] m);
        addend_t r;
        r.b        = '0;
        r.carry_in = 1'b0;
        case (pair)
            BOOTH_ADD: r.b = m;
            BOOTH_SUB: begin
                r.b        = ~m;
                r.carry_in = 1'b1;
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/booth_mul_seq_add32.sv
// add32: 32-bit carry-lookahead adder.
// Eight 4-bit lookahead groups; group carries ripple between groups.
// Ports:
//   a, b      in  32  addends
//   carry_in  in  1   carry into bit 0
//   sum       out 32  a + b + carry_in, low 32 bits
//   carry_out out 1   carry out of bit 31
module add32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        carry_in,
    output logic [31:0] sum,
    output logic        carry_out
);

    logic [31:0] g;
    logic [31:0] p;
    logic [8:0]  gc;

    assign g     = a & b;
    assign p     = a ^ b;
    assign gc[0] = carry_in;

    for (genvar k = 0; k < 8; k++) begin : g_group
        localparam int B = 4 * k;
        logic ci;
        logic c1, c2, c3;
        logic grp_g, grp_p;

        assign ci = gc[k];
        assign c1 = g[B] | (p[B] & ci);
        assign c2 = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & ci);
        assign c3 = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & ci);

        assign grp_g = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                     | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        assign grp_p = p[B+3] & p[B+2] & p[B+1] & p[B];

        assign gc[k+1] = grp_g | (grp_p & ci);

        assign sum[B+3:B] = p[B+3:B] ^ {c3, c2, c1, ci};
    end

    assign carry_out = gc[8];

endmodule

// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-2 Booth multiplier, signed 32 x 32 -> 64.
// One add/subtract-and-shift iteration per clock on a single shared add32;
// 32 iterations per product.
// Ports:
//   clock         in   1   system clock, rising edge
//   reset         in   1   synchronous, active-high
//   start         in   1   request, honoured only when idle
//   multiplicand  in   32  signed M, captured on accepted start
//   multiplier    in   32  signed Q, captured on accepted start
//   busy          out  1   high for the 32 iteration cycles
//   done          out  1   one-cycle pulse when hi/lo update
//   hi            out  32  product[63:32], held until next completion
//   lo            out  32  product[31:0],  held until next completion
module booth_mul_seq
    import booth_mul_seq_pkg::*;
#(
    parameter int WIDTH = booth_mul_seq_pkg::WIDTH,
    parameter int CNT_W = booth_mul_seq_pkg::CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t           state;
    state_t           state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic             q_1;
    logic [WIDTH-1:0] m_reg;
    logic [CNT_W-1:0] count;

    addend_t          addend;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout;
    logic             s32;
    logic [WIDTH-1:0] shift_a;
    logic [WIDTH-1:0] shift_q;
    logic             last_iter;

    assign addend = booth_addend({q_reg[0], q_1}, m_reg);

    add32 u_add32 (
        .a         (a_reg),
        .b         (addend.b),
        .carry_in  (addend.carry_in),
        .sum       (add_sum),
        .carry_out (add_cout)
    );

    // Bit 32 of the sign-extended sum. Using the operand signs rather than
    // carry_out alone keeps the result exact when M = 0x80000000.
    assign s32 = a_reg[WIDTH-1] ^ addend.b[WIDTH-1] ^ add_cout;

    // Arithmetic right shift of {s32, sum, Q, q_1}.
    assign shift_a = {s32, add_sum[WIDTH-1:1]};
    assign shift_q = {add_sum[0], q_reg[WIDTH-1:1]};

    assign last_iter = (count == CNT_W'(LAST_ITER));

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start)     state_next = S_RUN;
            S_RUN:  if (last_iter) state_next = S_IDLE;
            default:               state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            a_reg <= '0;
            q_reg <= '0;
            q_1   <= 1'b0;
            m_reg <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            done  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        m_reg <= multiplicand;
                        q_reg <= multiplier;
                        a_reg <= '0;
                        q_1   <= 1'b0;
                        count <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_RUN: begin
                    a_reg <= shift_a;
                    q_reg <= shift_q;
                    q_1   <= q_reg[0];
                    count <= count + 1'b1;
                    if (last_iter) begin
                        hi   <= shift_a;
                        lo   <= shift_q;
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: a table of directed products plus
// hand-written sequences for back-to-back start, start while busy, and
// reset during a run.
module tb_booth_mul_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] m;
        logic [31:0] q;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs[9];

    always #5 clock = ~clock;

    booth_mul_seq dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo)
    );

    task automatic check(input string name, input logic [63:0] actual,
                         input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, actual, expected);
        end
    endtask

    // Returns at the negedge after E0 with start low and the operand inputs
    // scrambled, so any late sampling of them would corrupt the product.
    task automatic launch(input logic [31:0] m, input logic [31:0] q);
        @(negedge clock);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        @(negedge clock);
        start        = 1'b0;
        multiplicand = ~m;
        multiplier   = q ^ 32'h5A5A_A5A5;
    endtask

    // Counts edges until done is seen (bounded); busy must hold until then.
    task automatic wait_done(output int edges, output bit busy_ok);
        edges   = 0;
        busy_ok = 1'b1;
        while (!done && edges < 40) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clock);
            edges++;
        end
    endtask

    initial begin
        int  edges;
        bit  busy_ok;
        bit  saw_done;

        vecs[0] = '{32'h0000_0006, 32'h0000_0007, 32'h0000_0000, 32'h0000_002A};
        vecs[1] = '{32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1};
        vecs[2] = '{32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
        vecs[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[4] = '{32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
        vecs[6] = '{32'h8000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        vecs[8] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};

        reset        = 1'b1;
        start        = 1'b1;
        multiplicand = 32'h0000_0003;
        multiplier   = 32'h0000_0003;
        repeat (3) @(negedge clock);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        start = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            launch(vecs[i].m, vecs[i].q);
            check($sformatf("v%0d_busy_after_start", i), {63'd0, busy}, 64'd1);
            wait_done(edges, busy_ok);
            check($sformatf("v%0d_latency", i), 64'(edges), 64'd32);
            check($sformatf("v%0d_busy_span", i), {63'd0, busy_ok}, 64'd1);
            check($sformatf("v%0d_busy_drop", i), {63'd0, busy}, 64'd0);
            check($sformatf("v%0d_product", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
            @(negedge clock);
            check($sformatf("v%0d_done_pulse", i), {63'd0, done}, 64'd0);
            check($sformatf("v%0d_hold", i), {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
        end

        // Back-to-back: start held during the done cycle is accepted.
        launch(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        wait_done(edges, busy_ok);
        check("b2b_first_latency", 64'(edges), 64'd32);
        check("b2b_first_product", {hi, lo}, 64'h3FFF_FFFF_0000_0001);
        start        = 1'b1;
        multiplicand = 32'h0000_0000;
        multiplier   = 32'h0000_1234;
        @(negedge clock);
        start = 1'b0;
        check("b2b_accepted", {63'd0, busy}, 64'd1);
        check("b2b_hold_during_run", {hi, lo}, 64'h3FFF_FFFF_0000_0001);
        wait_done(edges, busy_ok);
        check("b2b_second_latency", 64'(edges), 64'd32);
        check("b2b_second_busy_span", {63'd0, busy_ok}, 64'd1);
        check("b2b_second_product", {hi, lo}, 64'd0);

        // Start while busy is ignored and not queued.
        launch(32'd9, 32'd9);
        repeat (9) @(negedge clock);
        start        = 1'b1;
        multiplicand = 32'd2;
        multiplier   = 32'd2;
        @(negedge clock);
        start = 1'b0;
        wait_done(edges, busy_ok);
        check("busy_start_latency", 64'(edges), 64'd22);
        check("busy_start_product", {hi, lo}, 64'h51);
        @(negedge clock);
        check("busy_start_no_queue", {62'd0, busy, done}, 64'd0);

        // Reset at E12 aborts the run and clears the outputs.
        launch(32'd100, 32'd3);
        repeat (11) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        check("abort_hilo", {hi, lo}, 64'd0);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (done || busy) saw_done = 1'b1;
        end
        check("abort_no_done", {63'd0, saw_done}, 64'd0);
        launch(32'd100, 32'd3);
        wait_done(edges, busy_ok);
        check("after_abort_latency", 64'(edges), 64'd32);
        check("after_abort_product", {hi, lo}, 64'h12C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
